// File: rtl/seq_multiplier_ctrl.sv
// rtl/seq_multiplier_ctrl.sv - unsigned shift-and-add multiplier with IDLE/ADD/SHIFT ASM controller
// Product is {A, Q}; control strobes are decoded from state so sequencing is observable.
module seq_multiplier_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               ready,
  output logic               done,
  output logic               load_regs,
  output logic               add_en,
  output logic               shift_en
);

  localparam int PW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  b;
  logic              c;
  logic [PW-1:0]     p;
  logic              last_shift;

  assign last_shift = (p == '0);

  always_comb begin
    next_state = IDLE;
    ready      = 1'b0;
    load_regs  = 1'b0;
    add_en     = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        ready     = 1'b1;
        load_regs = start;
        next_state = start ? ADD : IDLE;
      end
      ADD: begin
        add_en     = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: begin
        shift_en   = 1'b1;
        next_state = last_shift ? IDLE : ADD;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      q     <= '0;
      b     <= '0;
      c     <= 1'b0;
      p     <= '0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      // p was already decremented by the preceding ADD, so p==0 here means final shift
      done  <= shift_en && last_shift;
      if (load_regs) begin
        b <= multiplicand;
        q <= multiplier;
        a <= '0;
        c <= 1'b0;
        p <= PW'(WIDTH);
      end else if (add_en) begin
        p <= p - 1'b1;
        if (q[0]) begin
          {c, a} <= {1'b0, a} + {1'b0, b};
        end
      end else if (shift_en) begin
        a <= {c, a[WIDTH-1:1]};
        q <= {a[0], q[WIDTH-1:1]};
        c <= 1'b0;
      end
    end
  end

  assign product = {a, q};

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// tb/tb_seq_multiplier_ctrl.sv - directed self-checking bench for seq_multiplier_ctrl
module tb_seq_multiplier_ctrl;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] product;
  logic               ready;
  logic               done;
  logic               load_regs;
  logic               add_en;
  logic               shift_en;

  int checks = 0;
  int errors = 0;

  seq_multiplier_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .ready        (ready),
    .done         (done),
    .load_regs    (load_regs),
    .add_en       (add_en),
    .shift_en     (shift_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start pulse and returns the product and cycles from accept edge to done.
  task automatic do_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        output logic [2*WIDTH-1:0] prod, output int lat);
    multiplicand = x;
    multiplier   = y;
    start        = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    prod = product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || product !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: ready=%b done=%b product=%h, expected ready=1 done=0 product=00",
                 i, ready, done, product);
      end
    end
  endtask

  task automatic test_basic();
    multiplicand = 4'd13;
    multiplier   = 4'd11;
    start        = 1'b1;
    #1;
    checks++;
    if (load_regs !== 1'b1) begin
      errors++;
      $display("FAIL basic_load_regs: got %b expected 1", load_regs);
    end
    tick();
    start = 1'b0;
    checks++;
    if (ready !== 1'b0 || add_en !== 1'b1 || shift_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_edge0: ready=%b add_en=%b shift_en=%b done=%b expected 0 1 0 0",
               ready, add_en, shift_en, done);
    end
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++;
      if (add_en !== ((k % 2) == 0) || shift_en !== ((k % 2) == 1) || done !== 1'b0 || ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_seq edge %0d: add_en=%b shift_en=%b done=%b ready=%b", k, add_en, shift_en, done, ready);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || ready !== 1'b1 || product !== 8'h8F) begin
      errors++;
      $display("FAIL basic_done: done=%b ready=%b product=%h expected 1 1 8f", done, ready, product);
    end
    tick();
    checks++;
    if (done !== 1'b0 || product !== 8'h8F || ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: done=%b product=%h ready=%b expected 0 8f 1", done, product, ready);
    end
  endtask

  task automatic test_carry_zero();
    logic [2*WIDTH-1:0] pr;
    int lat;
    do_mul(4'd15, 4'd15, pr, lat);
    checks++;
    if (pr !== 8'hE1 || lat != 8) begin
      errors++;
      $display("FAIL carry_15x15: product=%h lat=%0d expected e1 8", pr, lat);
    end
    do_mul(4'd0, 4'd9, pr, lat);
    checks++;
    if (pr !== 8'h00 || lat != 8) begin
      errors++;
      $display("FAIL zero_0x9: product=%h lat=%0d expected 00 8", pr, lat);
    end
    do_mul(4'd9, 4'd0, pr, lat);
    checks++;
    if (pr !== 8'h00 || lat != 8) begin
      errors++;
      $display("FAIL zero_9x0: product=%h lat=%0d expected 00 8", pr, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    multiplicand = 4'd3;
    multiplier   = 4'd5;
    start        = 1'b1;
    tick();
    multiplicand = 4'd15;
    multiplier   = 4'd15;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (product !== 8'h0F || lat != 8 || ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: product=%h lat=%0d ready=%b expected 0f 8 1", product, lat, ready);
    end
    multiplicand = 4'd6;
    multiplier   = 4'd7;
    #1;
    checks++;
    if (load_regs !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_on_done: load_regs=%b expected 1", load_regs);
    end
    tick();
    start = 1'b0;
    multiplicand = 4'd1;
    multiplier   = 4'd1;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (product !== 8'd42 || lat != 8) begin
      errors++;
      $display("FAIL b2b_second: product=%0d lat=%0d expected 42 8", product, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [2*WIDTH-1:0] pr;
    int lat;
    bit saw_done;
    multiplicand = 4'd13;
    multiplier   = 4'd11;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || product !== 8'h00 || done !== 1'b0 || add_en !== 1'b0 || shift_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: ready=%b product=%h done=%b add_en=%b shift_en=%b expected 1 00 0 0 0",
               ready, product, done, add_en, shift_en);
    end
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== 1'b0 || ready !== 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL rst_mid_quiet: done or busy seen after reset, expected idle with done=0");
    end
    do_mul(4'd2, 4'd3, pr, lat);
    checks++;
    if (pr !== 8'd6 || lat != 8) begin
      errors++;
      $display("FAIL rst_mid_after: product=%0d lat=%0d expected 6 8", pr, lat);
    end
  endtask

  task automatic test_sweep();
    logic [2*WIDTH-1:0] pr;
    logic [2*WIDTH-1:0] exp_p;
    int lat;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        exp_p = 8'(i * j);
        do_mul(4'(i), 4'(j), pr, lat);
        checks++;
        if (pr !== exp_p || lat != 8) begin
          errors++;
          $display("FAIL sweep %0dx%0d: product=%0d lat=%0d expected %0d 8", i, j, pr, lat, exp_p);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_zero();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
